// File: rtl/spi_mode0_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_mode0_slave_rx
//
// SPI mode 0 (CPOL=0, CPHA=0) slave receiver. Raw sclk/cs_n/mosi are
// synchronised into the clk domain, edges are detected with a one-flop delay,
// and MSB-first words of WORD_W bits are assembled and offered on a
// valid/ready interface. A response word captured at frame start is shifted
// out on miso, MSB first. Upper byte of a word is the command, lower byte data.
//
// Ports:
//   clk        system clock, at least 8x the SCLK frequency
//   rst_n      asynchronous active-low reset
//   sclk       raw SPI clock (asynchronous)
//   cs_n       raw chip select, active low (asynchronous)
//   mosi       raw serial data from the master
//   miso       serial response data, MSB first
//   miso_oe    miso output enable, 1 while selected
//   tx_data    response word, captured when the frame starts
//   rx_data    last accepted received word
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer accepts the word when rx_valid && rx_ready
//   frame_err  1-cycle pulse: frame ended with 1..WORD_W-1 bits
//   overrun    1-cycle pulse: word completed while the previous was unconsumed
// -----------------------------------------------------------------------------
module spi_mode0_slave_rx #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int               CNT_W    = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [SYNC_STAGES:0]   r_flush;
  logic                   r_armed;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  // FSM and datapath
  state_t                r_state;
  state_t                w_state_next;
  logic [WORD_W-1:0]     r_tx_shift;
  logic [WORD_W-2:0]     r_rx_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WORD_W-1:0]     r_rx_data;
  logic                  r_rx_valid;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic [WORD_W-1:0]     w_word;
  logic                  w_word_done;
  logic                  w_abort_err;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the pre-edge values of their neighbours, like real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush     <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      // Frames may only start once cs_n has been seen high after the
      // synchroniser has flushed its reset value; a chip select already low
      // when reset releases must not look like a falling edge.
      if (r_flush[SYNC_STAGES] && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d & r_armed;

  // Word as it stands after the current sclk rising edge.
  assign w_word      = {r_rx_shift, w_mosi_s};
  // cs_rise wins over a coincident sclk_rise.
  assign w_word_done = (r_state == SHIFT) && !w_cs_rise && w_sclk_rise &&
                       (r_bit_cnt == LAST_BIT);
  assign w_abort_err = (r_state == SHIFT) && w_cs_rise && (r_bit_cnt != '0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  // NOTE: the default assignment first means no path leaves w_state_next
  // unassigned, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_cs_rise)        w_state_next = IDLE;
        else if (w_word_done) w_state_next = WAIT_CS;
      end
      WAIT_CS: begin
        if (w_cs_rise) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    miso    = 1'b0;
    miso_oe = 1'b0;
    case (r_state)
      SHIFT: begin
        miso    = r_tx_shift[WORD_W-1];
        miso_oe = 1'b1;
      end
      WAIT_CS: miso_oe = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shift registers, bit counter, output handshake
  // NOTE: the shift registers are reset along with the control state so an
  // aborted frame leaves no residue behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_abort_err;
      r_overrun   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_tx_shift <= tx_data;
            r_bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (!w_cs_rise) begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_word[WORD_W-2:0];
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            end
            if (w_sclk_fall) begin
              r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
            end
          end
        end
        default: ;  // WAIT_CS: bit_cnt holds at WORD_W, sclk ignored
      endcase

      if (w_word_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= w_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;  // previous word kept, new one dropped
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_mode0_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_mode0_slave_rx
//
// Bench for spi_mode0_slave_rx: a bit-banged SPI mode 0 master drives frames
// of arbitrary length. A table of directed frames and a batch of random
// frames are checked against a frame-level model (word = first WORD_W bits
// sent, error for 1..WORD_W-1 bits, miso = response word MSB first then 0).
// Hand-written sequences cover overrun/handshake and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_spi_mode0_slave_rx;

  localparam int HALF = 8;  // clk cycles per SCLK half period (16x ratio)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;

  spi_mode0_slave_rx #(.WORD_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [15:0] tx;
    logic        exp_valid;
    logic [15:0] exp_word;
    logic        exp_ferr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Monitor state, sampled on the falling clock edge.
  int          cyc = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          valid_cycles = 0;
  int          valid_rise_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] got_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid) begin
      valid_cycles++;
      if (!prev_valid) valid_rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are sampled at the
  // falling edge, so nothing races.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One SCLK period: data set up, rising edge (miso sampled), falling edge.
  task automatic sclk_pulse(input logic b, output logic m, output logic oe, output int rise_cyc);
    mosi = b;
    tick(HALF);
    sclk     = 1'b1;
    m        = miso;
    oe       = miso_oe;
    rise_cyc = cyc;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input logic [15:0] tx,
                            output logic [31:0] miso_cap, output logic [31:0] oe_cap,
                            output int rise16);
    logic m, oe;
    int   rc;
    miso_cap = '0;
    oe_cap   = '0;
    rise16   = -1;
    tx_data  = tx;
    cs_n     = 1'b0;
    tick(HALF);
    for (int i = 0; i < n; i++) begin
      sclk_pulse(bits[n-1-i], m, oe, rc);
      miso_cap = {miso_cap[30:0], m};
      oe_cap   = {oe_cap[30:0], oe};
      if (i == 15) rise16 = rc;
    end
    tick(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(2 * HALF);
  endtask

  // Frame-level reference model.
  function automatic logic [15:0] model_word(input logic [31:0] bits, input int n);
    logic [31:0] s;
    s = bits >> (n - 16);
    return s[15:0];
  endfunction

  function automatic logic [31:0] model_miso(input logic [15:0] tx, input int n);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e = {e[30:0], (i < 16) ? tx[15-i] : 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] model_oe(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  task automatic run_vec(input vec_t v);
    int          q0, f0, o0, vc0, r16;
    logic [31:0] mc, oc;
    q0  = got_q.size();
    f0  = ferr_cnt;
    o0  = ovr_cnt;
    vc0 = valid_cycles;
    send_frame(v.bits, v.nbits, v.tx, mc, oc, r16);
    check("word_count", 32'(got_q.size() - q0), {31'd0, v.exp_valid});
    if (v.exp_valid && got_q.size() > q0) begin
      check("rx_data", {16'd0, got_q[q0]}, {16'd0, v.exp_word});
      check("valid_latency", 32'(valid_rise_cyc - r16), 32'd3);
      check("valid_width", 32'(valid_cycles - vc0), 32'd1);
    end
    check("frame_err", 32'(ferr_cnt - f0), {31'd0, v.exp_ferr});
    check("overrun", 32'(ovr_cnt - o0), 32'd0);
    check("miso_bits", mc, model_miso(v.tx, v.nbits));
    check("miso_oe_frame", oc, model_oe(v.nbits));
    check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[10];
    vec_t        v;
    int          q0, f0, o0, r16, rc;
    logic [31:0] mc, oc;
    logic        m, oe;
    logic [31:0] oe_acc, miso_acc;

    tbl[0] = '{32'h0000_10FF, 16, 16'hA5C3, 1'b1, 16'h10FF, 1'b0};
    tbl[1] = '{32'h0000_0155,  9, 16'h1357, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{32'h0000_00FF, 16, 16'hA5C3, 1'b1, 16'h00FF, 1'b0};
    tbl[3] = '{32'h000C_AFE5, 20, 16'h8001, 1'b1, 16'hCAFE, 1'b0};
    tbl[4] = '{32'h0000_0000,  0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{32'h0000_7FFF, 15, 16'hF00F, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{32'h0000_0001,  1, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[7] = '{32'h0000_FFFF, 16, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
    tbl[8] = '{32'h0000_0000, 16, 16'h0001, 1'b1, 16'h0000, 1'b0};
    tbl[9] = '{32'h0000_8001, 16, 16'h7FFE, 1'b1, 16'h8001, 1'b0};

    rst_n    = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 16'h0000;
    rx_ready = 1'b1;
    tick(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick(10);

    // Directed table.
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Overrun and handshake: two words with the consumer stalled.
    rx_ready = 1'b0;
    q0 = got_q.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(32'h1234, 16, 16'h0000, mc, oc, r16);
    check("ovr_valid1", {31'd0, rx_valid}, 32'd1);
    check("ovr_data1", {16'd0, rx_data}, 32'h1234);
    send_frame(32'hBEEF, 16, 16'h0000, mc, oc, r16);
    check("ovr_valid2", {31'd0, rx_valid}, 32'd1);
    check("ovr_data2", {16'd0, rx_data}, 32'h1234);
    check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("ovr_consumed", 32'(got_q.size() - q0), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_clear", {31'd0, rx_valid}, 32'd0);
    check("ovr_handoff", 32'(got_q.size() - q0), 32'd1);
    if (got_q.size() > q0) check("ovr_handoff_data", {16'd0, got_q[q0]}, 32'h1234);

    // Reset pulsed after 8 bits with cs_n held low.
    q0 = got_q.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    tx_data = 16'hFFFF;
    cs_n    = 1'b0;
    tick(HALF);
    for (int i = 0; i < 8; i++) sclk_pulse(1'b1, m, oe, rc);
    rst_n = 1'b0;
    #1;
    check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    oe_acc   = '0;
    miso_acc = '0;
    for (int i = 0; i < 8; i++) begin
      sclk_pulse(1'b1, m, oe, rc);
      oe_acc   = {oe_acc[30:0], oe};
      miso_acc = {miso_acc[30:0], m};
    end
    tick(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(2 * HALF);
    check("midrst_oe_after", oe_acc, 32'd0);
    check("midrst_miso_after", miso_acc, 32'd0);
    check("midrst_words", 32'(got_q.size() - q0), 32'd0);
    check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("midrst_ovr", 32'(ovr_cnt - o0), 32'd0);
    v = '{32'h0000_5A5A, 16, 16'h3C3C, 1'b1, 16'h5A5A, 1'b0};
    run_vec(v);

    // Random frames against the model.
    for (int k = 0; k < 25; k++) begin
      v.bits = $urandom;
      v.tx   = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    v.nbits = 16;
        2:       v.nbits = int'($urandom_range(1, 15));
        default: v.nbits = int'($urandom_range(17, 24));
      endcase
      v.exp_valid = (v.nbits >= 16);
      v.exp_word  = v.exp_valid ? model_word(v.bits, v.nbits) : 16'h0000;
      v.exp_ferr  = (v.nbits >= 1) && (v.nbits <= 15);
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mode0_slave_rx.md
Name: spi_mode0_slave_rx

Overview:
- SPI mode 0 (CPOL=0, CPHA=0) slave: the far end of the team's 16-bit SPI master transmitter.
- Oversamples raw sclk/cs_n/mosi in the clk domain and assembles MSB-first 16-bit words.
- Presents each word on a valid/ready interface; optionally shifts a response word out on miso.
- Sits at the FPGA pins feeding the command decoder: upper byte is the command, lower byte is the data.

Parameters:
- WORD_W, 16, bits per frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n, mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency (e.g. 27 MHz vs 1 MHz).
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  raw SPI clock from master; asynchronous to clk.
- cs_n  input  1  raw chip select, active low; asynchronous to clk.
- mosi  input  1  raw serial data from master.
- miso  output  1  serial response data, MSB first.
- miso_oe  output  1  miso output enable (1 while selected).
- tx_data  input  WORD_W  response word, captured at frame start.
- rx_data  output  WORD_W  last accepted received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
- frame_err  output  1  1-cycle pulse: frame ended with 1..WORD_W-1 bits.
- overrun  output  1  1-cycle pulse: word completed while the previous word was unconsumed.

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Synchronizers reset to the idle levels sclk=0, cs_n=1, mosi=0. bit_cnt=0, state=IDLE.
- Edge detection: a one-flop delay on each synchronized signal produces sclk_rise, sclk_fall, cs_fall, cs_rise as single-cycle strobes.
- Detection latency: SYNC_STAGES+1 clk cycles after the raw pin edge.
- State machine, IDLE:
  - miso_oe=0, miso=0; shift-register activity ignored.
  - On cs_fall: load tx_shift<=tx_data, bit_cnt<=0, go to SHIFT.
  - A low cs_n without a detected falling edge never starts a frame (e.g. reset released mid-frame).
- State machine, SHIFT:
  - miso_oe=1, miso=tx_shift[WORD_W-1].
  - sclk_rise: rx_shift<={rx_shift[WORD_W-2:0], mosi_sync}; bit_cnt increments.
  - sclk_fall: tx_shift shifts left one bit, filling with 0.
  - When bit_cnt reaches WORD_W, the word completes on that same sclk_rise cycle; go to WAIT_CS.
  - cs_rise before completion: if bit_cnt is 1..WORD_W-1, pulse frame_err and discard the partial word; if bit_cnt=0, no error. Go to IDLE.
- State machine, WAIT_CS:
  - Further sclk edges are ignored; miso=0, miso_oe=1.
  - cs_rise: go to IDLE, no error.
- Word completion output rules:
  - rx_valid=0: rx_data<=assembled word, rx_valid<=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: the new word loads and rx_valid stays 1 (no overrun).
  - rx_valid=1 and rx_ready=0: rx_data is kept (the new word is dropped) and overrun pulses.
- Handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready unless a new word completes in that cycle.
  - rx_data is stable while rx_valid=1.
- cs_rise and sclk_rise strobes in the same cycle: cs_rise has priority and the sclk edge is discarded.
- Reset asserted mid-frame: everything returns to reset values immediately. No valid, error or overrun is generated for the aborted frame.
- bit_cnt is width clog2(WORD_W)+1 and never wraps: it saturates in WAIT_CS.

Test Plan:
- Master sends 16'h10FF (MSB first, 1 MHz, clk 27 MHz), rx_ready=1:
  - rx_valid pulses one cycle with rx_data=16'h10FF, 3 clk after the 16th SCLK rising edge.
  - frame_err=0.
- tx_data=16'hA5C3 at cs_n fall, any MOSI pattern:
  - miso emits 1010_0101_1100_0011 MSB first, stable at every SCLK rising edge.
  - miso_oe=1 only while cs_n is low.
- Two frames 16'h1234 then 16'hBEEF, rx_ready=0 throughout:
  - rx_data stays 16'h1234 and rx_valid stays 1.
  - overrun pulses once at the second completion.
  - Raising rx_ready then clears rx_valid next cycle.
- cs_n rises after 9 SCLK pulses:
  - frame_err pulses once and rx_valid remains 0.
  - A following full frame 16'h00FF is received correctly.
- 20 SCLK pulses in one frame carrying 16'hCAFE then 4 extra bits:
  - exactly one word 16'hCAFE is delivered; no frame_err.
- rst_n pulsed low after 8 bits of a frame, cs_n still low:
  - no output activity until cs_n goes high then low again.
  - The next full frame 16'h5A5A is received correctly.
